// File: rtl/md_pkg.sv
// md_pkg: op encodings, FSM states and helpers for the mult/div unit.
// MD_UNIT_MADD_EN adds the MADD/MADDU/MSUB/MSUBU family.
package md_pkg;

  localparam int CNT_W = 6;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MTHI  = 4'd4,
    OP_MTLO  = 4'd5,
    OP_MFHI  = 4'd6,
    OP_MFLO  = 4'd7,
    OP_MADD  = 4'd8,
    OP_MADDU = 4'd9,
    OP_MSUB  = 4'd10,
    OP_MSUBU = 4'd11
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  function automatic logic is_div(
    input logic [3:0] op
  );
    return (op == OP_DIV) ||
           (op == OP_DIVU);
  endfunction

  // Ops that occupy the unit for several cycles.
  function automatic logic is_md_multi(
    input logic [3:0] op
  );
    logic m;
    m = (op == OP_MULT)  ||
        (op == OP_MULTU) ||
        is_div(op);
`ifdef MD_UNIT_MADD_EN
    m = m ||
        (op == OP_MADD)  ||
        (op == OP_MADDU) ||
        (op == OP_MSUB)  ||
        (op == OP_MSUBU);
`endif
    return m;
  endfunction

endpackage

// File: rtl/md_arith.sv
// md_arith: combinational mult/div datapath producing {hi,lo}.
// MD_UNIT_MADD_EN adds accumulate/subtract on {hi,lo}.
module md_arith
  import md_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]        op_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  input  logic [XLEN-1:0]   hi_i,
  input  logic [XLEN-1:0]   lo_i,
  output logic [2*XLEN-1:0] res_o,
  output logic              div0_o
);

  localparam logic [XLEN-1:0] MIN =
    {1'b1, {(XLEN-1){1'b0}}};

  logic [2*XLEN-1:0]      acc;
  logic [2*XLEN-1:0]      sprod;
  logic [2*XLEN-1:0]      uprod;
  logic signed [XLEN-1:0] sa;
  logic signed [XLEN-1:0] sb;
  logic                   bz;

  assign acc   = {hi_i, lo_i};
  assign sa    = a_i;
  assign sb    = b_i;
  assign bz    = (b_i == '0);
  assign sprod = {{XLEN{a_i[XLEN-1]}}, a_i} *
                 {{XLEN{b_i[XLEN-1]}}, b_i};
  assign uprod = {{XLEN{1'b0}}, a_i} *
                 {{XLEN{1'b0}}, b_i};

  assign div0_o = bz & is_div(op_i);

  // Select the result; divide by zero echoes the old {hi,lo}.
  always_comb begin
    res_o = acc;
    unique case (op_i)
      OP_MULT:  res_o = sprod;
      OP_MULTU: res_o = uprod;
      OP_DIV: begin
        if (bz)
          res_o = acc;
        else if (a_i == MIN && b_i == '1)
          res_o = {{XLEN{1'b0}}, MIN};
        else
          res_o = {sa % sb, sa / sb};
      end
      OP_DIVU: begin
        if (bz)
          res_o = acc;
        else
          res_o = {a_i % b_i, a_i / b_i};
      end
`ifdef MD_UNIT_MADD_EN
      OP_MADD:  res_o = acc + sprod;
      OP_MADDU: res_o = acc + uprod;
      OP_MSUB:  res_o = acc - sprod;
      OP_MSUBU: res_o = acc - uprod;
`endif
      default:  res_o = acc;
    endcase
  end

endmodule

// File: rtl/md_unit_pipe.sv
// md_unit_pipe: E-stage multi-cycle mult/div unit with HI/LO.
// MD_UNIT_MADD_EN enables MADD/MADDU/MSUB/MSUBU.
module md_unit_pipe
  import md_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [3:0]      op_code,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            cancel,
  output logic            busy,
  output logic            md_stall,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] rd_data
);

  localparam logic [CNT_W-1:0] MCNT =
    CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DCNT =
    CNT_W'(DIV_LAT - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*XLEN-1:0]   pend_q, pend_d;
  logic                wr_q, wr_d;
  logic [XLEN-1:0]     hi_q, hi_d;
  logic [XLEN-1:0]     lo_q, lo_d;
  logic [2*XLEN-1:0]   res;
  logic                div0;

  md_arith #(
    .XLEN (XLEN)
  ) u_arith (
    .op_i   (op_code),
    .a_i    (src_a),
    .b_i    (src_b),
    .hi_i   (hi_q),
    .lo_i   (lo_q),
    .res_o  (res),
    .div0_o (div0)
  );

  // State, counter, pending result and HI/LO registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      wr_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      wr_q    <= wr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Issue, countdown, cancel and write-back decisions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    wr_d    = wr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start && !cancel) begin
          if (is_md_multi(op_code)) begin
            state_d = S_RUN;
            cnt_d   = is_div(op_code) ? DCNT : MCNT;
            pend_d  = res;
            wr_d    = ~div0;
          end else if (op_code == OP_MTHI) begin
            hi_d = src_a;
          end else if (op_code == OP_MTLO) begin
            lo_d = src_a;
          end
        end
      end
      S_RUN: begin
        if (cancel) begin
          state_d = S_IDLE;
          wr_d    = 1'b0;
        end else if (cnt_q == '0) begin
          state_d = S_IDLE;
          wr_d    = 1'b0;
          if (wr_q) begin
            hi_d = pend_q[2*XLEN-1:XLEN];
            lo_d = pend_q[XLEN-1:0];
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = (state_q == S_RUN);
  assign md_stall = busy |
                    (start & is_md_multi(op_code));
  assign hi       = hi_q;
  assign lo       = lo_q;

  // MFHI/MFLO read port straight from HI/LO.
  always_comb begin
    rd_data = '0;
    if (op_code == OP_MFHI)
      rd_data = hi_q;
    else if (op_code == OP_MFLO)
      rd_data = lo_q;
  end

endmodule

// File: tb/tb_md_unit_pipe.sv
// tb_md_unit_pipe: directed scoreboard bench for md_unit_pipe.
// Expectations for MADDU follow MD_UNIT_MADD_EN.
module tb_md_unit_pipe;
  import md_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op_code;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        cancel;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  md_unit_pipe #(
    .XLEN     (32),
    .MULT_LAT (5),
    .DIV_LAT  (10)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op_code  (op_code),
    .src_a    (src_a),
    .src_b    (src_b),
    .cancel   (cancel),
    .busy     (busy),
    .md_stall (md_stall),
    .hi       (hi),
    .lo       (lo),
    .rd_data  (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset === 1'b1 && busy === 1'b1 &&
        start === 1'b1 && is_md_multi(op_code)) begin
      errors++;
      $error("FAIL issue_while_busy op=%0d", op_code);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: timeout");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic mt(input logic [3:0] op,
                    input logic [31:0] v);
    start   = 1'b1;
    op_code = op;
    src_a   = v;
    step();
    start   = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      step();
    end
  endtask

  task automatic pop_check(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb: got empty expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_hi"}, hi, e[63:32]);
      check({tag, "_lo"}, lo, e[31:0]);
    end
  endtask

  task automatic run_op(input string tag,
                        input logic [3:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] eh,
                        input logic [31:0] el,
                        input int lat);
    int n;
    exp_q.push_back({eh, el});
    start   = 1'b1;
    op_code = op;
    src_a   = a;
    src_b   = b;
    #1;
    check({tag, "_stall"}, {31'd0, md_stall}, 32'd1);
    step();
    start = 1'b0;
    wait_idle(n);
    check({tag, "_lat"}, 32'(n), 32'(lat));
    pop_check(tag);
  endtask

  initial begin
    int n;
    reset   = 1'b0;
    start   = 1'b0;
    cancel  = 1'b0;
    op_code = 4'd0;
    src_a   = '0;
    src_b   = '0;
    step();
    step();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b1;
    step();
    check("idle_stall", {31'd0, md_stall}, 32'd0);

    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'd3,
           32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    run_op("divu", OP_DIVU, 32'd100, 32'd7,
           32'd2, 32'd14, 10);
    run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    run_op("div_ovf", OP_DIV, 32'h8000_0000,
           32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10);
    run_op("multu_big", OP_MULTU, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 5);

    mt(OP_MTHI, 32'h11);
    mt(OP_MTLO, 32'h22);
    check("mt_nobusy", {31'd0, busy}, 32'd0);
    run_op("div0", OP_DIV, 32'd55, 32'd0,
           32'h11, 32'h22, 10);

    mt(OP_MTHI, 32'hDEAD);
    op_code = OP_MFHI;
    #1;
    check("mfhi", rd_data, 32'hDEAD);
    op_code = OP_MFLO;
    #1;
    check("mflo", rd_data, 32'h22);
    op_code = OP_MULT;
    #1;
    check("rd_other", rd_data, 32'd0);

    exp_q.push_back({32'd0, 32'd6});
    start   = 1'b1;
    op_code = OP_MULT;
    src_a   = 32'd2;
    src_b   = 32'd3;
    step();
    op_code = OP_MTLO;
    src_a   = 32'h999;
    step();
    start = 1'b0;
    check("mtlo_busy_lo", lo, 32'h22);
    check("mtlo_busy_b", {31'd0, busy}, 32'd1);
    wait_idle(n);
    check("mtlo_busy_lat", 32'(n + 1), 32'd5);
    pop_check("mtlo_busy");

    mt(OP_MTHI, 32'd0);
    mt(OP_MTLO, 32'd0);
    start   = 1'b1;
    op_code = OP_MULT;
    src_a   = 32'd5;
    src_b   = 32'd5;
    step();
    start = 1'b0;
    step();
    step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check("cancel_busy", {31'd0, busy}, 32'd0);
    step();
    check("cancel_busy2", {31'd0, busy}, 32'd0);
    check("cancel_hi", hi, 32'd0);
    check("cancel_lo", lo, 32'd0);

    mt(OP_MTHI, 32'd5);
    start   = 1'b1;
    op_code = OP_MULT;
    src_a   = 32'd5;
    src_b   = 32'd5;
    step();
    start = 1'b0;
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    repeat (6) step();
    check("rstmid_busy2", {31'd0, busy}, 32'd0);
    check("rstmid_hi", hi, 32'd0);
    check("rstmid_lo", lo, 32'd0);

    mt(OP_MTHI, 32'h33);
    start   = 1'b1;
    op_code = OP_MULT;
    src_a   = 32'd7;
    src_b   = 32'd7;
    step();
    start = 1'b0;
    repeat (4) step();
    check("lastcyc_busy", {31'd0, busy}, 32'd1);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check("lastcyc_b", {31'd0, busy}, 32'd0);
    check("lastcyc_hi", hi, 32'h33);
    check("lastcyc_lo", lo, 32'd0);

    start   = 1'b1;
    cancel  = 1'b1;
    op_code = OP_MULT;
    src_a   = 32'd9;
    src_b   = 32'd9;
    step();
    start = 1'b0;
    check("cxl_start", {31'd0, busy}, 32'd0);
    step();
    cancel = 1'b0;
    check("cxl_idle_b", {31'd0, busy}, 32'd0);
    check("cxl_idle_lo", lo, 32'd0);

    start   = 1'b1;
    op_code = 4'hF;
    src_a   = 32'hAAAA;
    #1;
    check("undef_stall", {31'd0, md_stall}, 32'd0);
    step();
    start = 1'b0;
    check("undef_busy", {31'd0, busy}, 32'd0);
    check("undef_hi", hi, 32'h33);

    mt(OP_MTHI, 32'd0);
    mt(OP_MTLO, 32'hFFFF_FFFF);
`ifdef MD_UNIT_MADD_EN
    run_op("maddu", OP_MADDU, 32'd1, 32'd1,
           32'd1, 32'd0, 5);
    mt(OP_MTHI, 32'd0);
    mt(OP_MTLO, 32'd0);
    run_op("msub", OP_MSUB, 32'd2, 32'd3,
           32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
`else
    start   = 1'b1;
    op_code = OP_MADDU;
    src_a   = 32'd1;
    src_b   = 32'd1;
    #1;
    check("maddu_stall", {31'd0, md_stall}, 32'd0);
    step();
    start = 1'b0;
    n = 0;
    repeat (6) begin
      if (busy === 1'b1)
        n++;
      step();
    end
    check("maddu_busy", 32'(n), 32'd0);
    check("maddu_hi", hi, 32'd0);
    check("maddu_lo", lo, 32'hFFFF_FFFF);
`endif

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL sb_empty: got %0d expected 0",
             exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/md_unit_pipe.md
Name: md_unit_pipe

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO registers, sitting in the E stage of the five-stage pipeline.
- Successor to the fixed-width, fixed-latency mult/div path: operand width and per-operation latency are set by parameters.
- Adds an explicit cancel input for flushes and a stall request for the hazard unit.
- MFHI/MFLO are served combinationally from the HI/LO registers; MTHI/MTLO complete in a single cycle.

Parameters:
- XLEN, 32, operand and HI/LO width.
- MULT_LAT, 5, busy cycles for MULT/MULTU (legal range 1..63).
- DIV_LAT, 10, busy cycles for DIV/DIVU (legal range 1..63).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clk edge).
- start  in  1  issue op_code this cycle.
- op_code  in  4  operation, encoded in md_pkg.
- src_a  in  XLEN  rs operand.
- src_b  in  XLEN  rt operand.
- cancel  in  1  abort the in-flight op (pipeline flush).
- busy  out  1  multi-cycle op in flight.
- md_stall  out  1  combinational stall request = busy | (start & op is MULT/DIV family).
- hi  out  XLEN  HI register.
- lo  out  XLEN  LO register.
- rd_data  out  XLEN  MFHI→hi, MFLO→lo, otherwise 0.

Behaviour:
- Reset: busy=0, hi=0, lo=0, counter=0, pending result cleared, state=IDLE.
- States:
  - IDLE: start & (MULT|MULTU|DIV|DIVU) → RUN.
    - Compute the 2*XLEN result at the issue edge into a pending register.
    - Load counter with MULT_LAT-1 or DIV_LAT-1.
    - busy=1 from the next cycle.
  - RUN: counter decrements each cycle.
    - When counter==0, the next edge writes pending into hi/lo, clears busy and returns to IDLE.
    - busy is therefore high for exactly LAT cycles.
    - hi/lo become visible on the cycle after busy falls.
  - MTHI/MTLO in IDLE: hi or lo ← src_a at the edge. No busy.
  - MFHI/MFLO: no state change; rd_data reflects the current hi/lo.
- Arithmetic:
  - MULT: signed XLEN×XLEN → {hi,lo}.
  - MULTU: unsigned XLEN×XLEN → {hi,lo}.
  - DIV/DIVU: lo=quotient, hi=remainder. Signed remainder takes the sign of the dividend (truncating division).
  - Signed overflow (min_int / -1): lo=min_int, hi=0.
  - Divide by zero: the op still runs DIV_LAT cycles; hi/lo are left unchanged.
- Boundaries:
  - start while busy: ignored (the hazard unit must not issue; bench asserts this never happens).
  - cancel in RUN: the next edge returns to IDLE with busy=0; hi/lo keep their pre-op values.
  - cancel in the same cycle as start: the op is not issued.
  - cancel in IDLE: no effect.
  - cancel on the final RUN cycle: cancel wins, no write.
  - Reset mid-operation: everything returns to reset values, including the pending result.
  - MTHI/MTLO while busy: ignored.
  - Undefined op_code values: no-op.

Optional Feature:
- Macro MD_UNIT_MADD_EN.
  - When defined, op_code adds MADD, MADDU, MSUB, MSUBU.
  - Each op forms the XLEN×XLEN product as in MULT/MULTU, adds it to or subtracts it from {hi,lo} (captured at issue), wraps modulo 2^(2*XLEN), and uses MULT_LAT timing.
- When not defined, these encodings are undefined ops and behave as no-ops.

Decomposition:
- md_pkg holds:
  - the op_code enum (MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO, MADD, MADDU, MSUB, MSUBU);
  - an is_md_multi helper;
  - the counter width constant CNT_W=6.
- Sub-module md_arith: purely combinational, takes op, src_a, src_b, hi, lo and returns the 2*XLEN result plus a div0 flag.
- md_unit_pipe owns the FSM, counter, pending register and HI/LO.

Test Plan:
- MULT src_a=0xFFFFFFFE (-2), src_b=3 → busy for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- DIVU 100/7 with DIV_LAT=10 → busy for 10 cycles; then lo=14, hi=2. Signed DIV -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0. DIV by 0 with hi=0x11, lo=0x22 beforehand → after 10 cycles hi=0x11, lo=0x22.
- MTHI 0xDEAD, then MFHI → rd_data=0xDEAD on the following cycle. MTLO issued while busy → lo unchanged.
- MULT 5×5 with cancel on RUN cycle 3 (hi=lo=0 beforehand) → busy=0 next cycle, hi=lo=0. Repeat with reset=0 on cycle 2 → same result.
- MD_UNIT_MADD_EN defined, hi=0, lo=0xFFFFFFFF, MADDU 1×1 → hi=1, lo=0. Macro undefined, same op → hi/lo unchanged, busy never asserted.
